note_sequencer: RTL and testbench

Walks the notes of the selected song in the song ROM and hands each note to the note player through a pulse handshake. It sits between the top-level play/pause/next controller and the note player. It obeys the controller's `play`, `reset_play` and `song` outputs and returns the `song_done` pulse that ends a song.

---
 rtl/note_seq_pkg.sv | 19 +
 rtl/song_rom.sv | 20 ++
 rtl/note_sequencer.sv | 108 ++++++++++
 tb/tb_note_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared types and default widths for the note sequencer slice.
package note_seq_pkg;
    localparam int unsigned DEF_NOTE_AW = 5;
    localparam int unsigned DEF_NOTE_W  = 6;
    localparam int unsigned DEF_DUR_W   = 6;
    localparam int unsigned SONG_W      = 2;
    localparam int unsigned DEF_WORD_W  = DEF_NOTE_W + DEF_DUR_W;

    // ROM word is {note, duration}: duration in the low bits.
    localparam int unsigned DEF_DUR_LSB  = 0;
    localparam int unsigned DEF_NOTE_LSB = DEF_DUR_W;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        WAIT,
        END
    } seq_state_t;
endpackage

// File: rtl/song_rom.sv
// Registered song ROM, 4 songs of 2^NOTE_AW {note, duration} words.
module song_rom
  import note_seq_pkg::*;
#(
  parameter int unsigned NOTE_AW   = DEF_NOTE_AW,
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter string       INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic [SONG_W+NOTE_AW-1:0] addr,
  output logic [WORD_W-1:0]         data
);
  localparam int unsigned DEPTH = 1 << (SONG_W + NOTE_AW);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end
endmodule

// File: rtl/note_sequencer.sv
// Walks the selected song's ROM entries and hands each note to the player via a pulse handshake.
// Optional NOTE_SEQ_END_MARKER_EN: a duration-0 ROM word ends the song early.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned NOTE_AW = DEF_NOTE_AW,
    parameter int unsigned NOTE_W  = DEF_NOTE_W,
    parameter int unsigned DUR_W   = DEF_DUR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      reset_play,
    input  logic [SONG_W-1:0]         song,
    output logic [SONG_W+NOTE_AW-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]   rom_data,
    output logic [NOTE_W-1:0]         note,
    output logic [DUR_W-1:0]          duration,
    output logic                      new_note,
    input  logic                      note_done,
    output logic                      song_done
);
    localparam int unsigned NOTE_LSB = DUR_W;

    seq_state_t         state, state_n;
    logic [NOTE_AW-1:0] idx, idx_n;
    logic [NOTE_W-1:0]  note_n;
    logic [DUR_W-1:0]   dur_n;
    logic               new_note_n, song_done_n;
    logic               end_marker;

    assign rom_addr = {song, idx};

`ifdef NOTE_SEQ_END_MARKER_EN
    assign end_marker = (rom_data[0 +: DUR_W] == '0);
`else
    assign end_marker = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        note_n      = note;
        dur_n       = duration;
        new_note_n  = 1'b0;
        song_done_n = 1'b0;

        case (state)
            FETCH: if (play) state_n = ISSUE;
            ISSUE: begin
                if (play) begin
                    if (end_marker) begin
                        state_n     = END;
                        song_done_n = 1'b1;
                        idx_n       = '0;
                    end else begin
                        note_n     = rom_data[NOTE_LSB +: NOTE_W];
                        dur_n      = rom_data[0 +: DUR_W];
                        new_note_n = 1'b1;
                        state_n    = WAIT;
                    end
                end
            end
            WAIT: begin
                // End-of-song is checked before the increment so idx never wraps.
                if (note_done) begin
                    if (idx == '1) begin
                        state_n     = END;
                        song_done_n = 1'b1;
                        idx_n       = '0;
                    end else begin
                        idx_n   = idx + NOTE_AW'(1);
                        state_n = FETCH;
                    end
                end
            end
            END:     state_n = END;
            default: state_n = FETCH;
        endcase

        if (reset_play) begin
            state_n     = FETCH;
            idx_n       = '0;
            note_n      = note;
            dur_n       = duration;
            new_note_n  = 1'b0;
            song_done_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            idx       <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            note      <= note_n;
            duration  <= dur_n;
            new_note  <= new_note_n;
            song_done <= song_done_n;
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer driven from song_rom, against a counter-based reference model.
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int unsigned AW   = 5;
    localparam int unsigned NW   = 6;
    localparam int unsigned DW   = 6;
    localparam int unsigned WW   = NW + DW;
    localparam int          LAST = (1 << AW) - 1;
`ifdef NOTE_SEQ_END_MARKER_EN
    localparam bit MARKER = 1'b1;
`else
    localparam bit MARKER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1, play = 1'b0, reset_play = 1'b0, note_done = 1'b0;
    logic [1:0]    song = '0;
    logic [6:0]    rom_addr;
    logic [WW-1:0] rom_data;
    logic [NW-1:0] note;
    logic [DW-1:0] duration;
    logic          new_note, song_done;

    logic [WW-1:0] rom_m [128];
    int total = 0;
    int bad   = 0;

    // Reference model: position in song, play-cycles still needed before issue, outstanding/finished flags.
    int          m_pos, m_need;
    bit          m_busy, m_fin, m_nn, m_sd;
    logic [NW-1:0] m_note;
    logic [DW-1:0] m_dur;

    always #5 clk = ~clk;

    song_rom #(.NOTE_AW(AW), .WORD_W(WW)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    note_sequencer #(.NOTE_AW(AW), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .reset_play (reset_play),
        .song       (song),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .duration   (duration),
        .new_note   (new_note),
        .note_done  (note_done),
        .song_done  (song_done)
    );

    function automatic logic [6:0] exp_addr();
        return {song, 5'(m_pos)};
    endfunction

    task automatic tick(input logic r, input logic p, input logic rp, input logic nd, input logic [1:0] s);
        logic [WW-1:0] w;
        @(negedge clk);
        reset = r; play = p; reset_play = rp; note_done = nd; song = s;
        m_nn = 1'b0;
        m_sd = 1'b0;
        if (r) begin
            m_pos = 0; m_need = 2; m_busy = 0; m_fin = 0; m_note = '0; m_dur = '0;
        end else if (rp) begin
            m_pos = 0; m_need = 2; m_busy = 0; m_fin = 0;
        end else if (m_fin) begin
            m_fin = 1'b1;
        end else if (m_busy) begin
            if (nd) begin
                m_busy = 1'b0;
                if (m_pos == LAST) begin
                    m_fin = 1'b1; m_sd = 1'b1; m_pos = 0;
                end else begin
                    m_pos++; m_need = 2;
                end
            end
        end else if (p) begin
            m_need--;
            if (m_need == 0) begin
                w = rom_m[int'(s) * 32 + m_pos];
                if (MARKER && w[DW-1:0] == '0) begin
                    m_fin = 1'b1; m_sd = 1'b1; m_pos = 0;
                end else begin
                    m_note = w[WW-1:DW]; m_dur = w[DW-1:0]; m_nn = 1'b1; m_busy = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick(1, 0, 0, 0, 0);
        total++;
        if ({new_note, song_done, note, duration, rom_addr} !== {2'b00, 12'h000, 7'h00}) begin
            bad++;
            $display("FAIL reset: actual nn=%b sd=%b note=%0d dur=%0d addr=%h required all zero",
                     new_note, song_done, note, duration, rom_addr);
        end
    endtask

    task automatic test_first_note();
        logic [WW-1:0] w;
        tick(0, 1, 0, 0, 0);
        total++;
        if (new_note !== 1'b0 || rom_addr !== 7'h00) begin
            bad++;
            $display("FAIL first_cyc1: actual nn=%b addr=%h required nn=0 addr=00", new_note, rom_addr);
        end
        tick(0, 1, 0, 0, 0);
        total++;
        if (new_note !== 1'b1 || note !== 6'd12 || duration !== 6'd4) begin
            bad++;
            $display("FAIL first_cyc2: actual nn=%b note=%0d dur=%0d required nn=1 note=12 dur=4",
                     new_note, note, duration);
        end
        repeat (8) tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0);
        total++;
        if (rom_addr !== 7'h01) begin
            bad++;
            $display("FAIL next_addr: actual addr=%h required 01", rom_addr);
        end
        tick(0, 1, 0, 0, 0);
        total++;
        if (new_note !== 1'b0) begin
            bad++;
            $display("FAIL next_early: actual nn=%b required 0", new_note);
        end
        tick(0, 1, 0, 0, 0);
        w = rom_m[1];
        total++;
        if (new_note !== 1'b1 || note !== w[WW-1:DW] || duration !== w[DW-1:0]) begin
            bad++;
            $display("FAIL next_note: actual nn=%b note=%0d dur=%0d required nn=1 note=%0d dur=%0d",
                     new_note, note, duration, w[WW-1:DW], w[DW-1:0]);
        end
    endtask

    task automatic test_play_pause();
        logic [WW-1:0] w;
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0);
            total++;
            if (new_note !== 1'b0) begin
                bad++;
                $display("FAIL pause_%0d: actual nn=%b required 0", i, new_note);
            end
        end
        tick(0, 1, 0, 0, 0);
        w = rom_m[2];
        total++;
        if (new_note !== 1'b1 || note !== w[WW-1:DW]) begin
            bad++;
            $display("FAIL resume: actual nn=%b note=%0d required nn=1 note=%0d", new_note, note, w[WW-1:DW]);
        end
    endtask

    task automatic test_song_end();
        logic [WW-1:0] w;
        tick(0, 0, 1, 0, 2);
        total++;
        if (rom_addr !== 7'h40) begin
            bad++;
            $display("FAIL song2_start: actual addr=%h required 40", rom_addr);
        end
        for (int i = 0; i < 32; i++) begin
            tick(0, 1, 0, 0, 2);
            tick(0, 1, 0, 0, 2);
            total++;
            if ({new_note, note, duration, rom_addr} !== {m_nn, m_note, m_dur, exp_addr()}) begin
                bad++;
                $display("FAIL song2_issue%0d: actual nn=%b note=%0d dur=%0d addr=%h required nn=%b note=%0d dur=%0d addr=%h",
                         i, new_note, note, duration, rom_addr, m_nn, m_note, m_dur, exp_addr());
            end
            tick(0, 1, 0, 1, 2);
        end
        total++;
        if (song_done !== 1'b1 || new_note !== 1'b0 || rom_addr !== 7'h40) begin
            bad++;
            $display("FAIL song2_done: actual sd=%b nn=%b addr=%h required sd=1 nn=0 addr=40",
                     song_done, new_note, rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 1, 2);
            total++;
            if (song_done !== 1'b0 || new_note !== 1'b0 || rom_addr !== 7'h40) begin
                bad++;
                $display("FAIL end_hold%0d: actual sd=%b nn=%b addr=%h required sd=0 nn=0 addr=40",
                         i, song_done, new_note, rom_addr);
            end
        end
        tick(0, 0, 1, 0, 2);
        tick(0, 1, 0, 0, 2);
        tick(0, 1, 0, 0, 2);
        w = rom_m[64];
        total++;
        if (new_note !== 1'b1 || note !== w[WW-1:DW] || rom_addr !== 7'h40) begin
            bad++;
            $display("FAIL restart: actual nn=%b note=%0d addr=%h required nn=1 note=%0d addr=40",
                     new_note, note, rom_addr, w[WW-1:DW]);
        end
    endtask

    task automatic test_collision();
        logic [WW-1:0] w;
        tick(0, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            tick(0, 1, 0, 0, 1);
            tick(0, 1, 0, 0, 1);
            tick(0, 1, 0, 1, 1);
        end
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        w = rom_m[39];
        total++;
        if (new_note !== 1'b1 || note !== w[WW-1:DW] || rom_addr !== 7'h27) begin
            bad++;
            $display("FAIL idx7_issue: actual nn=%b note=%0d addr=%h required nn=1 note=%0d addr=27",
                     new_note, note, rom_addr, w[WW-1:DW]);
        end
        tick(0, 1, 1, 1, 1);
        total++;
        if (rom_addr !== 7'h20 || song_done !== 1'b0 || new_note !== 1'b0) begin
            bad++;
            $display("FAIL collide: actual addr=%h sd=%b nn=%b required addr=20 sd=0 nn=0",
                     rom_addr, song_done, new_note);
        end
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        w = rom_m[32];
        total++;
        if (new_note !== 1'b1 || note !== w[WW-1:DW]) begin
            bad++;
            $display("FAIL collide_restart: actual nn=%b note=%0d required nn=1 note=%0d",
                     new_note, note, w[WW-1:DW]);
        end
    endtask

    task automatic test_end_marker();
        logic [WW-1:0] w;
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0, 0);
            tick(0, 1, 0, 0, 0);
            w = rom_m[i];
            total++;
            if (new_note !== 1'b1 || note !== w[WW-1:DW] || duration !== w[DW-1:0]) begin
                bad++;
                $display("FAIL marker_note%0d: actual nn=%b note=%0d dur=%0d required nn=1 note=%0d dur=%0d",
                         i, new_note, note, duration, w[WW-1:DW], w[DW-1:0]);
            end
            tick(0, 1, 0, 1, 0);
        end
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        w = rom_m[3];
`ifdef NOTE_SEQ_END_MARKER_EN
        total++;
        if (song_done !== 1'b1 || new_note !== 1'b0 || rom_addr !== 7'h00) begin
            bad++;
            $display("FAIL marker_end: actual sd=%b nn=%b addr=%h required sd=1 nn=0 addr=00",
                     song_done, new_note, rom_addr);
        end
`else
        total++;
        if (new_note !== 1'b1 || song_done !== 1'b0 || duration !== 6'd0 || note !== w[WW-1:DW]) begin
            bad++;
            $display("FAIL dur0_note: actual nn=%b sd=%b note=%0d dur=%0d required nn=1 sd=0 note=%0d dur=0",
                     new_note, song_done, note, duration, w[WW-1:DW]);
        end
`endif
    endtask

    task automatic test_random();
        logic       p, rp, nd, pnn, psd;
        logic [1:0] s;
        s = 2'd3;
        tick(0, 0, 1, 0, s);
        pnn = new_note;
        psd = song_done;
        for (int c = 0; c < 3000; c++) begin
            rp = ($urandom_range(0, 999) < 3);
            if (rp) s = 2'($urandom_range(0, 3));
            p  = ($urandom_range(0, 99) < 75);
            nd = ($urandom_range(0, 99) < 25);
            tick(0, p, rp, nd, s);
            total++;
            if ({new_note, song_done, note, duration, rom_addr} !== {m_nn, m_sd, m_note, m_dur, exp_addr()}) begin
                bad++;
                $display("FAIL rand_%0d: actual nn=%b sd=%b note=%0d dur=%0d addr=%h required nn=%b sd=%b note=%0d dur=%0d addr=%h",
                         c, new_note, song_done, note, duration, rom_addr, m_nn, m_sd, m_note, m_dur, exp_addr());
            end
            total++;
            if ((new_note && song_done) || (new_note && pnn) || (song_done && psd)) begin
                bad++;
                $display("FAIL pulse_rule_%0d: actual nn=%b sd=%b prev_nn=%b prev_sd=%b required single non-overlapping pulses",
                         c, new_note, song_done, pnn, psd);
            end
            pnn = new_note;
            psd = song_done;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom_m[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        end
        rom_m[0]  = {6'd12, 6'd4};
        rom_m[3]  = {6'($urandom_range(0, 63)), 6'd0};
        rom_m[106] = {6'd9, 6'd0};
        for (int i = 0; i < 128; i++) u_rom.mem[i] = rom_m[i];

        test_reset();
        test_first_note();
        test_play_pause();
        test_song_end();
        test_collision();
        test_end_marker();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
